mem_load_receiver: RTL and testbench

Load-side counterpart of the store-path byte-write transmitter. It accepts a load request (address plus RISC-V func3) from the core and issues a word-aligned read to the byte-addressed memory. It then waits for read data, extracts and sign- or zero-extends the addressed byte, halfword or word, and returns the result over a valid/ready response handshake. Misaligned or illegal loads and memory timeouts are reported as errors.

---
 rtl/mem_load_if.sv | 30 +++
 rtl/mem_load_receiver.sv | 175 +++++++++++++++++
 tb/tb_mem_load_receiver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_load_if.sv
// mem_load_if: bundles the load-request, memory-read and load-response
// channels of mem_load_receiver.
//   slave  : the receiver's view. It accepts ld_*, drives mem_req/mem_addr,
//            consumes mem_rvalid/mem_rdata and drives the load_* response.
//   master : the core/memory side, which is the mirror image of slave.
interface mem_load_if #(parameter int ADDR_W = 32);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        func3;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              load_err;
  logic [1:0]        err_code;

  modport slave (
    input  ld_valid, ld_addr, func3, mem_rvalid, mem_rdata, load_ready,
    output ld_ready, mem_req, mem_addr, load_valid, load_data, load_err, err_code
  );

  modport master (
    output ld_valid, ld_addr, func3, mem_rvalid, mem_rdata, load_ready,
    input  ld_ready, mem_req, mem_addr, load_valid, load_data, load_err, err_code
  );
endinterface

// File: rtl/mem_load_receiver.sv
// mem_load_receiver: takes one RISC-V load (address + func3) at a time,
// issues a word-aligned read strobe to memory, waits for read data with a
// timeout, then returns the byte/half/word result over a valid/ready
// response handshake.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : mem_load_if.slave, which carries
//                ld_valid/ld_ready/ld_addr/func3        load request
//                mem_req/mem_addr/mem_rvalid/mem_rdata  memory read
//                load_valid/load_ready/load_data/load_err/err_code  response
// err_code: 00 none, 01 misaligned, 10 illegal func3, 11 timeout.
module mem_load_receiver #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_load_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_MIS  = 2'b01;
  localparam logic [1:0] E_F3   = 2'b10;
  localparam logic [1:0] E_TO   = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              lv_q, lv_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        lo_q, lo_d;
  logic [2:0]        f3_q, f3_d;

  logic f3_legal, misaligned;

  // Byte/half/word select plus sign or zero extension. func3[2] marks the
  // unsigned variants, func3[1:0] the access size.
  function automatic logic [31:0] extract(input logic [31:0] rd,
                                          input logic [1:0]  lo,
                                          input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  always_comb begin
    f3_legal = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) ||
               (bus.func3 == 3'b010) || (bus.func3 == 3'b100) ||
               (bus.func3 == 3'b101);
    misaligned = ((bus.func3[1:0] == 2'b01) && bus.ld_addr[0]) ||
                 ((bus.func3[1:0] == 2'b10) && (bus.ld_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d    = state;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    lv_d       = lv_q;
    data_d     = data_q;
    err_d      = err_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    f3_d       = f3_q;
    case (state)
      IDLE: begin
        if (bus.ld_valid) begin
          lo_d = bus.ld_addr[1:0];
          f3_d = bus.func3;
          if (!f3_legal) begin
            state_d = RESP;
            lv_d    = 1'b1;
            data_d  = '0;
            err_d   = 1'b1;
            code_d  = E_F3;
          end else if (misaligned) begin
            // rejected before any memory access
            state_d = RESP;
            lv_d    = 1'b1;
            data_d  = '0;
            err_d   = 1'b1;
            code_d  = E_MIS;
          end else begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.ld_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = RESP;
          lv_d    = 1'b1;
          data_d  = extract(bus.mem_rdata, lo_q, f3_q);
          err_d   = 1'b0;
          code_d  = E_NONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          lv_d    = 1'b1;
          data_d  = '0;
          err_d   = 1'b1;
          code_d  = E_TO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        // response fields stay frozen until consumed
        if (bus.load_ready) begin
          state_d = IDLE;
          lv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      lv_q       <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      code_q     <= E_NONE;
      cnt_q      <= '0;
      lo_q       <= '0;
      f3_q       <= '0;
    end else begin
      state      <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      lv_q       <= lv_d;
      data_q     <= data_d;
      err_q      <= err_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      f3_q       <= f3_d;
    end
  end

  assign bus.ld_ready   = (state == IDLE);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.load_valid = lv_q;
  assign bus.load_data  = data_q;
  assign bus.load_err   = err_q;
  assign bus.err_code   = code_q;

endmodule

// File: tb/tb_mem_load_receiver.sv
// Directed bench for mem_load_receiver: expected responses are queued when a
// load is launched and popped when the DUT presents load_valid.
module tb_mem_load_receiver;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mreq_cnt = 0;
  exp_t sb[$];

  localparam logic [31:0] RD = 32'h1234_F678;
  localparam logic [31:0] RD2 = 32'h8001_0000;

  mem_load_if #(.ADDR_W(32)) bus();

  mem_load_receiver #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // count cycles in which the read strobe is high
  always @(negedge clk) if (bus.mem_req === 1'b1) mreq_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] f3);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.func3    = f3;
    chk("ld_ready_at_issue", 32'(bus.ld_ready), 32'd1);
    step();
    bus.ld_valid = 1'b0;
  endtask

  // legal load up to the point where load_valid should be visible
  task automatic legal_go(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input int dly, input logic [31:0] exp_d);
    int m0;
    exp_t e;
    m0 = mreq_cnt;
    e.data = exp_d; e.err = 1'b0; e.code = 2'b00;
    sb.push_back(e);
    issue(addr, f3);
    chk({tag, "_mem_req_n1"}, 32'(bus.mem_req), 32'd1);
    chk({tag, "_mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
    step();
    chk({tag, "_mem_req_n2"}, 32'(bus.mem_req), 32'd0);
    repeat (dly) step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    chk({tag, "_mem_req_once"}, 32'(mreq_cnt - m0), 32'd1);
  endtask

  task automatic take_resp(input string tag);
    exp_t e;
    chk({tag, "_load_valid"}, 32'(bus.load_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, bus.load_data, e.data);
      chk({tag, "_err"}, 32'(bus.load_err), 32'(e.err));
      chk({tag, "_code"}, 32'(bus.err_code), 32'(e.code));
    end
    bus.load_ready = 1'b1;
    step();
    bus.load_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.load_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.ld_ready), 32'd1);
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                    input logic [31:0] rdata, input int dly, input logic [31:0] exp_d);
    legal_go(tag, addr, f3, rdata, dly, exp_d);
    take_resp(tag);
  endtask

  task automatic bad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [1:0] code);
    int m0;
    exp_t e;
    m0 = mreq_cnt;
    e.data = 32'd0; e.err = 1'b1; e.code = code;
    sb.push_back(e);
    issue(addr, f3);
    chk({tag, "_no_mem_req"}, 32'(bus.mem_req), 32'd0);
    take_resp(tag);
    chk({tag, "_no_access"}, 32'(mreq_cnt - m0), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'd1);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_load_valid"}, 32'(bus.load_valid), 32'd0);
    chk({tag, "_load_data"}, bus.load_data, 32'd0);
    chk({tag, "_load_err"}, 32'(bus.load_err), 32'd0);
    chk({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
  endtask

  initial begin
    int n;
    exp_t e;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.func3 = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.load_ready = 1'b0;

    #3;
    chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // byte loads
    ld("lb_101",  32'h101, 3'b000, RD, 0, 32'hFFFF_FFF6);
    ld("lbu_101", 32'h101, 3'b100, RD, 1, 32'h0000_00F6);
    ld("lb_103",  32'h103, 3'b000, RD, 0, 32'h0000_0012);
    ld("lb_100",  32'h100, 3'b000, RD, 2, 32'h0000_0078);
    ld("lbu_102", 32'h102, 3'b100, RD, 0, 32'h0000_0034);
    // halfword / word loads
    ld("lh_100",  32'h100, 3'b001, RD, 0, 32'hFFFF_F678);
    ld("lhu_100", 32'h100, 3'b101, RD, 0, 32'h0000_F678);
    ld("lh_102",  32'h102, 3'b001, RD, 1, 32'h0000_1234);
    ld("lw_100",  32'h100, 3'b010, RD, 3, 32'h1234_F678);
    ld("lh_102n", 32'h102, 3'b001, RD2, 0, 32'hFFFF_8001);
    ld("lhu_102n", 32'h102, 3'b101, RD2, 0, 32'h0000_8001);

    // error paths: response the cycle after accept, no memory access
    bad("lw_102",  32'h102, 3'b010, 2'b01);
    bad("lw_101",  32'h101, 3'b010, 2'b01);
    bad("lh_101",  32'h101, 3'b001, 2'b01);
    bad("f3_011",  32'h100, 3'b011, 2'b10);
    bad("f3_110",  32'h100, 3'b110, 2'b10);
    bad("f3_111",  32'h101, 3'b111, 2'b10);

    // timeout: 16 WAIT cycles without rvalid
    e.data = 32'd0; e.err = 1'b1; e.code = 2'b11;
    sb.push_back(e);
    issue(32'h200, 3'b010);
    step();
    n = 0;
    while (bus.load_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    take_resp("timeout");
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = RD;
    repeat (3) begin
      step();
      chk("late_rvalid_no_resp", 32'(bus.load_valid), 32'd0);
    end
    bus.mem_rvalid = 1'b0;

    // backpressure, then back-to-back accept
    legal_go("bp", 32'h100, 3'b001, RD, 0, 32'hFFFF_F678);
    repeat (5) begin
      chk("bp_valid_hold", 32'(bus.load_valid), 32'd1);
      chk("bp_data_hold", bus.load_data, 32'hFFFF_F678);
      chk("bp_err_hold", 32'(bus.load_err), 32'd0);
      chk("bp_ld_ready", 32'(bus.ld_ready), 32'd0);
      step();
    end
    take_resp("bp");
    ld("b2b", 32'h103, 3'b100, RD, 0, 32'h0000_0012);

    // reset while waiting for read data
    issue(32'h300, 3'b010);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = RD;
    repeat (3) begin
      step();
      chk("post_rst_no_resp", 32'(bus.load_valid), 32'd0);
      chk("post_rst_idle", 32'(bus.ld_ready), 32'd1);
    end
    bus.mem_rvalid = 1'b0;
    ld("post_rst_lw", 32'h104, 3'b010, RD2, 0, RD2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
